example_mac_pipe_sat: RTL and testbench
=======================================

Name: example_mac_pipe_sat

Overview:
Parametrised, pipelined signed multiply-accumulate unit. It is the successor to the single-cycle combinational signed multiplier cores used in the example datapath. It adds configurable operand/result widths, a configurable pipeline depth, valid/ready flow control with backpressure, per-beat accumulate framing (first/last) and optional output saturation. It sits between HLS-generated stream stages wherever a dot-product or scaled product is computed.

Parameters:
DIN0_WIDTH, 14, signed operand A width (>=2)
DIN1_WIDTH, 8, signed operand B width (>=2)
DOUT_WIDTH, 21, signed result width (>=2, <=ACC_WIDTH)
ACC_WIDTH, 32, accumulator width (>=DIN0_WIDTH+DIN1_WIDTH)
NUM_STAGE, 3, product pipeline register stages (>=1)
SAT, 1, 1 = saturate result to DOUT_WIDTH; 0 = truncate (keep low DOUT_WIDTH bits)

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst  in  1  synchronous active-high reset
din0  in  DIN0_WIDTH  signed operand A
din1  in  DIN1_WIDTH  signed operand B
in_first  in  1  beat starts a new accumulation (clear before add)
in_last  in  1  beat ends accumulation (emit result)
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
dout  out  DOUT_WIDTH  signed result
dout_ovf  out  1  result was saturated/truncated out of range
out_valid  out  1  dout valid
out_ready  in  1  downstream accepts dout

Behaviour:
- Interface: one clock, ap_clk. Reset ap_rst is synchronous and active-high.
- Reset: out_valid=0, dout=0, dout_ovf=0, accumulator=0, all stage valid bits=0. Reset wins over every other event. A reset mid-accumulation discards all in-flight beats and the partial sum.
- Global enable: ce = !out_valid | out_ready.
  - in_ready = ce (combinational).
  - A beat is accepted when in_valid & in_ready.
  - All pipeline, accumulator and output registers update only when ce=1.
- Product pipeline:
  - Full-precision signed product of width DIN0_WIDTH+DIN1_WIDTH.
  - Carried with its first/last flags and a valid bit through NUM_STAGE registers.
  - Stage valid=0 (bubble) whenever no beat is accepted.
- Accumulate stage (stage NUM_STAGE+1):
  - Applies when the stage-NUM_STAGE entry is valid.
  - acc_next = (first ? 0 : acc) + sign-extended product, mod 2^ACC_WIDTH (two's complement wrap, no flag).
  - acc <= acc_next.
  - If last=1: dout <= fmt(acc_next), dout_ovf <= range flag, out_valid <= 1.
  - Otherwise: out_valid <= 0 when ce.
  - An invalid entry leaves acc unchanged and clears out_valid when ce.
- fmt:
  - SAT=1: clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; ovf=1 iff a clamp occurred.
  - SAT=0: low DOUT_WIDTH bits; ovf=1 iff the value is not representable.
- Latency: accepted beat with last=1 produces out_valid exactly NUM_STAGE+1 ce-cycles later.
- Throughput: one beat per cycle while out_ready=1.
- first=1 & last=1: plain multiply (one output per beat).
- first=1 with no preceding last: partial sum silently discarded.
- last without first: continues the current sum.
- Backpressure: while out_valid=1 & out_ready=0, dout, dout_ovf and out_valid hold stable, in_ready=0 and the pipeline freezes. Nothing is dropped or duplicated.
- Simultaneous out handshake and new result: the new result replaces the old one in the same cycle, so out_valid stays 1.

Test Plan:
1. Plain multiply, defaults: din0=100, din1=-3, first=last=1 at cycle 0, out_ready=1 -> cycle 4: out_valid=1, dout=-300, ovf=0; out_valid=0 at cycle 5.
2. Accumulate 4 beats back-to-back: (10,10,first), (20,-5), (7,3), (1,1,last) -> a single output dout=22 four cycles after the last beat; no out_valid on intermediate beats.
3. Saturation: single beat -8192 x -128 -> dout=1048575, ovf=1. With SAT=0 -> dout=-1048576, ovf=1.
4. Accumulated saturation: 8 beats of 8191 x 127 -> dout=1048575, ovf=1. 8 beats of -8192 x 127 -> dout=-1048576, ovf=1.
5. Backpressure: stream 6 single-beat products while out_ready is held low for 5 cycles mid-stream -> dout stable while stalled, in_ready=0, all 6 results emitted in order with correct values, none lost or duplicated.
6. Reset mid-operation: 2 beats (first, then non-last), assert ap_rst for 1 cycle, then beat (3,4,first,last) -> no spurious output; dout=12 at NUM_STAGE+1 cycles after acceptance.

Source files
------------

// File: rtl/example_mac_pipe_sat.sv
// ---------------------------------------------------------------------------
// example_mac_pipe_sat
//   Pipelined signed multiply-accumulate with valid/ready flow control,
//   first/last accumulation framing and optional output saturation.
//
//   A full-precision product is formed at the input and carried through
//   NUM_STAGE registers along with its first/last flags and a valid bit.
//   The stage after the last product register accumulates (wrapping at
//   ACC_WIDTH) and, on a 'last' beat, formats the sum into dout.
//   The whole datapath advances only on ce = !out_valid | out_ready.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   din0       in   signed operand A  [DIN0_WIDTH]
//   din1       in   signed operand B  [DIN1_WIDTH]
//   in_first   in   beat starts a new accumulation
//   in_last    in   beat ends accumulation and emits a result
//   in_valid   in   input beat valid
//   in_ready   out  block accepts a beat this cycle (= ce)
//   dout       out  signed result [DOUT_WIDTH]
//   dout_ovf   out  result was clamped (SAT=1) or not representable (SAT=0)
//   out_valid  out  dout valid
//   out_ready  in   downstream accepts dout
// ---------------------------------------------------------------------------
module example_mac_pipe_sat #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 8,
    parameter int DOUT_WIDTH = 21,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_STAGE  = 3,
    parameter int SAT        = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    logic                        w_ce;
    logic signed [PW-1:0]        w_a;
    logic signed [PW-1:0]        w_b;
    logic signed [PW-1:0]        w_mult;

    logic signed [PW-1:0]        r_prod [NUM_STAGE];
    logic [NUM_STAGE-1:0]        r_vld;
    logic [NUM_STAGE-1:0]        r_first;
    logic [NUM_STAGE-1:0]        r_last;
    logic [NUM_STAGE:0]          w_vld_in;
    logic [NUM_STAGE:0]          w_first_in;
    logic [NUM_STAGE:0]          w_last_in;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_acc_base;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_fits;
    logic [DOUT_WIDTH-1:0]       w_fmt;
    logic                        w_ovf;

    logic                        r_out_valid;
    logic [DOUT_WIDTH-1:0]       r_dout;
    logic                        r_ovf;

    assign w_ce     = !r_out_valid | out_ready;
    assign in_ready = w_ce;

    // Operands are sign-extended to the product width first, so the low PW
    // bits of the PW x PW multiply are the exact signed product.
    assign w_a    = PW'($signed(din0));
    assign w_b    = PW'($signed(din1));
    assign w_mult = w_a * w_b;

    // Shift-in vectors: bit 0 is the new beat, upper bits are the current
    // stages. Works unchanged for NUM_STAGE = 1.
    assign w_vld_in   = {r_vld,   in_valid};
    assign w_first_in = {r_first, in_first};
    assign w_last_in  = {r_last,  in_last};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                r_prod[i] <= '0;
            end
        end else if (w_ce) begin
            // Bubble (valid=0) whenever no beat is accepted.
            r_vld   <= w_vld_in[NUM_STAGE-1:0];
            r_first <= w_first_in[NUM_STAGE-1:0];
            r_last  <= w_last_in[NUM_STAGE-1:0];
            r_prod[0] <= w_mult;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    // Accumulate stage: two's complement wrap at ACC_WIDTH.
    assign w_prod_ext = ACC_WIDTH'(r_prod[NUM_STAGE-1]);
    assign w_acc_base = r_first[NUM_STAGE-1] ? '0 : r_acc;
    assign w_acc_next = w_acc_base + w_prod_ext;

    // The sum fits DOUT_WIDTH iff every bit from the result sign bit upward
    // equals the accumulator sign bit.
    assign w_fits = (&w_acc_next[ACC_WIDTH-1:DOUT_WIDTH-1]) |
                    ~(|w_acc_next[ACC_WIDTH-1:DOUT_WIDTH-1]);

    always_comb begin
        w_fmt = w_acc_next[DOUT_WIDTH-1:0];
        w_ovf = !w_fits;
        if ((SAT != 0) && !w_fits) begin
            // Clamp toward the sign of the true sum: 100..0 or 011..1.
            w_fmt = {w_acc_next[ACC_WIDTH-1],
                     {(DOUT_WIDTH-1){~w_acc_next[ACC_WIDTH-1]}}};
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_acc       <= '0;
            r_dout      <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_ce) begin
            if (r_vld[NUM_STAGE-1]) begin
                r_acc <= w_acc_next;
                if (r_last[NUM_STAGE-1]) begin
                    r_dout      <= w_fmt;
                    r_ovf       <= w_ovf;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign dout_ovf  = r_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_example_mac_pipe_sat.sv
// ---------------------------------------------------------------------------
// tb_example_mac_pipe_sat
//   Two instances share all inputs: one saturating (SAT=1), one truncating
//   (SAT=0). Expected results are queued per instance when a 'last' beat is
//   accepted and popped on each output handshake.
// ---------------------------------------------------------------------------
module tb_example_mac_pipe_sat;

    localparam int DW0 = 14;
    localparam int DW1 = 8;
    localparam int DWO = 21;
    localparam int AW  = 32;
    localparam int NS  = 3;

    logic           ap_clk;
    logic           ap_rst;
    logic [DW0-1:0] din0;
    logic [DW1-1:0] din1;
    logic           in_first;
    logic           in_last;
    logic           in_valid;
    logic           out_ready;

    logic           in_ready_s, in_ready_t;
    logic [DWO-1:0] dout_s, dout_t;
    logic           ovf_s, ovf_t;
    logic           ov_s, ov_t;

    example_mac_pipe_sat #(
        .DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DWO),
        .ACC_WIDTH(AW), .NUM_STAGE(NS), .SAT(1)
    ) u_sat (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0), .din1(din1),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready_s), .dout(dout_s), .dout_ovf(ovf_s),
        .out_valid(ov_s), .out_ready(out_ready)
    );

    example_mac_pipe_sat #(
        .DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DWO),
        .ACC_WIDTH(AW), .NUM_STAGE(NS), .SAT(0)
    ) u_trn (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0), .din1(din1),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready_t), .dout(dout_t), .dout_ovf(ovf_t),
        .out_valid(ov_t), .out_ready(out_ready)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int a;
        int b;
        bit f;
        bit l;
        int es;
        bit eso;
        int et;
        bit eto;
    } vec_t;

    typedef struct {
        logic [DWO-1:0] d;
        logic           o;
    } exp_t;

    vec_t vecs[$];
    exp_t q_s[$];
    exp_t q_t[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out_s = 0;
    int n_out_t = 0;
    bit mon_en = 1'b0;

    logic signed [31:0] acc_m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t fmt_sat(input logic signed [31:0] v);
        exp_t e;
        if (v > 32'sd1048575) begin
            e.d = 21'h0FFFFF; e.o = 1'b1;
        end else if (v < -32'sd1048576) begin
            e.d = 21'h100000; e.o = 1'b1;
        end else begin
            e.d = v[20:0]; e.o = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t fmt_trn(input logic signed [31:0] v);
        exp_t e;
        e.d = v[20:0];
        e.o = (v > 32'sd1048575) || (v < -32'sd1048576);
        return e;
    endfunction

    task automatic push_exp(input int es, input bit eso, input int et, input bit eto);
        exp_t e;
        e.d = es[20:0]; e.o = eso; q_s.push_back(e);
        e.d = et[20:0]; e.o = eto; q_t.push_back(e);
    endtask

    task automatic addv(input int a, input int b, input bit f, input bit l,
                        input int es, input bit eso, input int et, input bit eto);
        vec_t v;
        v.a = a; v.b = b; v.f = f; v.l = l;
        v.es = es; v.eso = eso; v.et = et; v.eto = eto;
        vecs.push_back(v);
    endtask

    // Drive one beat starting at posedge+1; returns at posedge+1 after the
    // edge that accepted it. Keeps the bench model sum in step.
    task automatic send(input int a, input int b, input bit f, input bit l, input bit push);
        int guard;
        logic signed [31:0] p;
        din0 = a[DW0-1:0]; din1 = b[DW1-1:0];
        in_first = f; in_last = l; in_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge ap_clk);
            if (in_ready_s) break;
            guard++;
            if (guard > 100) begin
                chk("send_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        p = a * b;
        acc_m = f ? p : acc_m + p;
        if (l && push) begin
            q_s.push_back(fmt_sat(acc_m));
            q_t.push_back(fmt_trn(acc_m));
        end
    endtask

    // Called right after send() of a last beat: out_valid must rise exactly
    // on the 4th cycle after acceptance and drop on the 5th.
    task automatic latency_check(input string nm);
        for (int k = 1; k <= NS + 2; k++) begin
            @(negedge ap_clk);
            chk(nm, 64'({ov_s, ov_t}), (k == NS + 1) ? 64'd3 : 64'd0);
        end
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while ((q_s.size() != 0 || q_t.size() != 0) && guard < 200) begin
            @(negedge ap_clk);
            guard++;
        end
        if (guard >= 200) chk(nm, 64'(q_s.size() + q_t.size()), 64'd0);
        repeat (6) @(negedge ap_clk);
        @(posedge ap_clk); #1;
    endtask

    // Output monitor / scoreboard plus stall-stability checks.
    logic           p_stall;
    logic [DWO+1:0] p_s, p_t;

    always @(negedge ap_clk) begin
        if (ap_rst || !mon_en) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("stall_hold_sat", 64'({ov_s, dout_s, ovf_s}), 64'(p_s));
                chk("stall_hold_trn", 64'({ov_t, dout_t, ovf_t}), 64'(p_t));
            end
            if (ov_s && !out_ready) chk("stall_in_ready", 64'({in_ready_s, in_ready_t}), 64'd0);
            if (!ov_s) chk("idle_in_ready", 64'({in_ready_s, in_ready_t}), 64'd3);
            if (ov_s && out_ready) begin
                n_out_s++;
                if (q_s.size() == 0) chk("out_sat_unexpected", 64'({dout_s, ovf_s}), 64'hDEAD);
                else begin
                    exp_t e;
                    e = q_s.pop_front();
                    chk("out_sat", 64'({dout_s, ovf_s}), 64'({e.d, e.o}));
                end
            end
            if (ov_t && out_ready) begin
                n_out_t++;
                if (q_t.size() == 0) chk("out_trn_unexpected", 64'({dout_t, ovf_t}), 64'hDEAD);
                else begin
                    exp_t e;
                    e = q_t.pop_front();
                    chk("out_trn", 64'({dout_t, ovf_t}), 64'({e.d, e.o}));
                end
            end
            p_stall = ov_s && !out_ready;
            p_s = {ov_s, dout_s, ovf_s};
            p_t = {ov_t, dout_t, ovf_t};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int o_s0, o_t0;
        ap_rst = 1'b1; din0 = '0; din1 = '0; in_first = 1'b0; in_last = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; acc_m = '0;

        // Vector table: {a, b, first, last, sat dout, sat ovf, trunc dout, trunc ovf}
        addv(100, -3, 1, 1, -300, 0, -300, 0);
        addv(10, 10, 1, 0, 0, 0, 0, 0);
        addv(20, -5, 0, 0, 0, 0, 0, 0);
        addv(7, 3, 0, 0, 0, 0, 0, 0);
        addv(1, 1, 0, 1, 22, 0, 22, 0);
        addv(-8192, -128, 1, 1, 1048575, 1, -1048576, 1);
        for (int i = 0; i < 8; i++) addv(8191, 127, i == 0, i == 7, 1048575, 1, -66552, 1);
        for (int i = 0; i < 8; i++) addv(-8192, 127, i == 0, i == 7, -1048576, 1, 65536, 1);
        addv(8191, 127, 1, 0, 0, 0, 0, 0);
        addv(8191, 1, 0, 0, 0, 0, 0, 0);
        addv(127, 1, 0, 1, 1048575, 0, 1048575, 0);
        addv(8191, 127, 1, 0, 0, 0, 0, 0);
        addv(8191, 1, 0, 0, 0, 0, 0, 0);
        addv(127, 1, 0, 0, 0, 0, 0, 0);
        addv(1, 1, 0, 1, 1048575, 1, -1048576, 1);
        addv(-8192, 127, 1, 0, 0, 0, 0, 0);
        addv(-8192, 1, 0, 1, -1048576, 0, -1048576, 0);
        addv(50, 50, 1, 0, 0, 0, 0, 0);
        addv(2, 3, 1, 1, 6, 0, 6, 0);
        addv(4, 5, 1, 1, 20, 0, 20, 0);
        addv(1, 2, 0, 1, 22, 0, 22, 0);

        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("reset_sat", 64'({ov_s, dout_s, ovf_s, in_ready_s}), 64'd1);
        chk("reset_trn", 64'({ov_t, dout_t, ovf_t, in_ready_t}), 64'd1);
        mon_en = 1'b1;
        @(posedge ap_clk); #1;

        // Plain multiply with exact latency.
        push_exp(-300, 0, -300, 0);
        send(100, -3, 1, 1, 0);
        latency_check("latency_mul");
        drain("drain_mul");

        // Table, back-to-back beats.
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].l, 0);
            if (vecs[i].l) push_exp(vecs[i].es, vecs[i].eso, vecs[i].et, vecs[i].eto);
        end
        drain("drain_table");

        // Backpressure: 6 single-beat products, out_ready low 5 cycles mid-stream.
        o_s0 = n_out_s; o_t0 = n_out_t;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int a, b;
                    a = int'($urandom_range(16383)) - 8192;
                    b = int'($urandom_range(255)) - 128;
                    send(a, b, 1, 1, 1);
                end
            end
            begin
                repeat (6) @(posedge ap_clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_bp");
        chk("bp_count", 64'({n_out_s - o_s0, n_out_t - o_t0}), {32'd6, 32'd6});

        // Reset discards an in-flight last beat.
        send(5, 6, 1, 1, 0);
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        drain("drain_rst_last");

        // Reset mid-accumulation, then a fresh plain multiply.
        send(5, 6, 1, 0, 1);
        send(7, 8, 0, 0, 1);
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        acc_m = '0;
        push_exp(12, 0, 12, 0);
        send(3, 4, 1, 1, 0);
        latency_check("latency_rst");
        drain("drain_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
